// File: rtl/seg7_mux_driver_if.sv
// Display-load bus: one digit set (nibbles, decimal points, blank mask) per valid/ready transfer.
// The master holds the fields stable while load_valid is high; the slave raises load_ready when its shadow buffer is empty.
interface seg7_mux_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    load_valid;
  logic                    load_ready;

  modport master (
    output value, dp_in, blank_mask, load_valid,
    input  load_ready
  );

  modport slave (
    input  value, dp_in, blank_mask, load_valid,
    output load_ready
  );
endinterface

// File: rtl/seg7_mux_driver.sv
// Multiplexed common-anode 7-seg scanner with a shadow/active buffer pair, PWM dimming and LZ suppression.
// Outputs are registered, one cycle behind slot_cnt/dig; a load stalls (load_ready low) until the next frame boundary commits it.
module seg7_mux_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_LOG2 = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_mux_driver_if.slave      ld,
  input  logic                  lz_suppress,
  input  logic [3:0]            brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick
);

  localparam logic [2:0] LAST_DIG = 3'(NUM_DIGITS - 1);

  logic [REFRESH_LOG2-1:0] slot_cnt_q;
  logic [2:0]              dig_q;
  logic                    pend_q;

  logic [4*NUM_DIGITS-1:0] sh_val_q, act_val_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q, act_dp_q;
  logic [NUM_DIGITS-1:0]   sh_blank_q, act_blank_q;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_tick_q, frame_tick_d;

  logic slot_end, boundary, accept;
  logic [3:0] cur_nib;
  logic cur_dp, cur_blank, cur_sup, zero_run;
  logic pwm_on, dark, lit;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0001100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  assign slot_end      = &slot_cnt_q;
  assign boundary      = slot_end && (dig_q == LAST_DIG);
  assign ld.load_ready = !pend_q;
  assign accept        = ld.load_valid && !pend_q;

  // Zero run is tracked from the top digit down; digit 0 always stays visible.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_sup   = 1'b0;
    zero_run  = lz_suppress;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_val_q[4*i +: 4] == 4'h0);
      if (dig_q == 3'(i)) begin
        cur_nib   = act_val_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_blank = act_blank_q[i];
        cur_sup   = zero_run && (i != 0);
      end
    end
  end

  assign pwm_on = (slot_cnt_q[REFRESH_LOG2-1 -: 4] <= brightness);
  assign dark   = cur_blank || cur_sup;
  assign lit    = !dark && pwm_on;

  always_comb begin
    seg_d        = dark ? 7'h7F : decode(cur_nib);
    dp_d         = dark || !cur_dp;
    frame_tick_d = (dig_q == 3'd0) && (slot_cnt_q == '0);
    an_d         = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = !(lit && (dig_q == 3'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q   <= '0;
      dig_q        <= 3'd0;
      pend_q       <= 1'b0;
      sh_val_q     <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_q + 1'b1;
      if (slot_end) begin
        dig_q <= (dig_q == LAST_DIG) ? 3'd0 : dig_q + 3'd1;
      end

      // A load accepted on the boundary cycle lands only in the shadow and waits a full frame.
      if (boundary && pend_q) begin
        act_val_q   <= sh_val_q;
        act_dp_q    <= sh_dp_q;
        act_blank_q <= sh_blank_q;
      end
      if (accept) begin
        sh_val_q   <= ld.value;
        sh_dp_q    <= ld.dp_in;
        sh_blank_q <= ld.blank_mask;
      end
      if (accept) begin
        pend_q <= 1'b1;
      end else if (boundary) begin
        pend_q <= 1'b0;
      end

      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule
